// File: rtl/alu_sel_arbiter.sv
// Round-robin arbiter sharing one ALU result path among 8 requesters.
// Grants one requester at a time, pulses start, waits for alu_done (or timeout), then acks.
module alu_sel_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       alu_done,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       start,
    output logic [7:0] ack,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [2:0] sel_reg, sel_next;
    logic [7:0] gnt_reg, gnt_next;
    logic [7:0] ack_reg, ack_next;
    logic       start_reg, start_next;
    logic       err_reg, err_next;
    logic       busy_reg, busy_next;
    logic [7:0] cnt_reg, cnt_next;

    logic [2:0] rot_idx [8];
    logic [7:0] req_rot;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic       timeout_hit;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit then wins.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_idx[gi] = ptr_reg + 3'(gi);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) win_off = 3'(i);
        end
    end

    assign winner      = ptr_reg + win_off;
    assign timeout_hit = (cnt_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 3'd0;
            sel_reg   <= 3'd0;
            gnt_reg   <= 8'd0;
            ack_reg   <= 8'd0;
            start_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            start_reg <= start_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (|req) state_next = ST_BUSY;
            ST_BUSY: if (alu_done || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decided from the current state.
    always_comb begin
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        gnt_next   = 8'd0;
        ack_next   = 8'd0;
        start_next = 1'b0;
        err_next   = 1'b0;
        busy_next  = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    sel_next   = winner;
                    gnt_next   = 8'b1 << winner;
                    start_next = 1'b1;
                    busy_next  = 1'b1;
                    cnt_next   = 8'd0;
                end
            end
            ST_BUSY: begin
                busy_next = 1'b1;
                if (cnt_reg != 8'(TIMEOUT)) cnt_next = cnt_reg + 8'd1;
                if (alu_done || timeout_hit) begin
                    ack_next = gnt_reg;
                    err_next = ~alu_done;
                    ptr_next = sel_reg + 3'd1;
                end else begin
                    gnt_next = gnt_reg;
                end
            end
            default: ;
        endcase
    end

    assign sel   = sel_reg;
    assign gnt   = gnt_reg;
    assign ack   = ack_reg;
    assign start = start_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_alu_sel_arbiter.sv
// Self-checking bench for alu_sel_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_alu_sel_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       alu_done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       start;
    logic [7:0] ack;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;
    int last_sel = 0;

    logic [21:0] obs;
    assign obs = {sel, gnt, start, ack, err, busy};

    alu_sel_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .alu_done(alu_done),
        .sel(sel), .gnt(gnt), .start(start), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] pk(input int s, input logic [7:0] g, input logic st,
                                       input logic [7:0] a, input logic e, input logic b);
        return {3'(s), g, st, a, e, b};
    endfunction

    // First requesting index scanning ptr, ptr+1, ... modulo 8.
    function automatic int rr_pick(input int p, input logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation starting from IDLE; returns the winner and leaves DUT in IDLE.
    task automatic run_txn(input logic [7:0] reqv, input int done_k, input int drop_k,
                           input logic done_in_done, output int w);
        logic [21:0] e;
        logic [7:0]  oh;
        logic        exp_err;
        logic        fin;
        int          k;
        w  = rr_pick(ptr_m, reqv);
        oh = 8'b1 << w;
        req = reqv;
        tick;
        e = pk(w, oh, 1'b1, 8'd0, 1'b0, 1'b1);
        if (obs !== e) begin
            $display("FAIL grant req=%h: got %h want %h", reqv, obs, e);
            n_bad++;
        end
        n_cmp++;
        fin = 1'b0;
        exp_err = 1'b0;
        k = 1;
        while (!fin && k <= TO + 1) begin
            alu_done = (k == done_k);
            if (k == drop_k) req[w] = 1'b0;
            tick;
            alu_done = 1'b0;
            if (k == done_k || k == TO) begin
                fin = 1'b1;
                exp_err = (k != done_k);
                e = pk(w, 8'd0, 1'b0, oh, exp_err, 1'b1);
                if (obs !== e) begin
                    $display("FAIL ack req=%h cyc=%0d: got %h want %h", reqv, k, obs, e);
                    n_bad++;
                end
            end else begin
                e = pk(w, oh, 1'b0, 8'd0, 1'b0, 1'b1);
                if (obs !== e) begin
                    $display("FAIL busy req=%h cyc=%0d: got %h want %h", reqv, k, obs, e);
                    n_bad++;
                end
            end
            n_cmp++;
            k++;
        end
        req[w] = 1'b0;
        alu_done = done_in_done;
        tick;
        alu_done = 1'b0;
        e = pk(w, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        if (obs !== e) begin
            $display("FAIL release req=%h: got %h want %h", reqv, obs, e);
            n_bad++;
        end
        n_cmp++;
        ptr_m = (w + 1) % 8;
        last_sel = w;
        $display("txn req=%h winner=%0d done_cyc=%0d err=%0d", reqv, w, done_k, exp_err);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        ptr_m = 0;
        last_sel = 0;
    endtask

    task automatic test_reset;
        req = 8'd0;
        alu_done = 1'b0;
        do_reset;
        if (obs !== 22'd0) begin
            $display("FAIL reset: got %h want %h", obs, 22'd0);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_single;
        int w;
        run_txn(8'h04, 4, 0, 1'b0, w);
        run_txn(8'h04, 3, 0, 1'b0, w);
        req = 8'd0;
    endtask

    task automatic test_round_robin;
        logic [7:0] mask;
        int w;
        do_reset;
        mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            run_txn(mask, 2, 0, 1'b0, w);
            if (w != i) begin
                $display("FAIL rr_order: got %0d want %0d", w, i);
                n_bad++;
            end
            n_cmp++;
            mask[w] = 1'b0;
        end
        req = 8'd0;
    endtask

    task automatic test_wrap;
        int w;
        run_txn(8'h20, 2, 0, 1'b0, w);
        run_txn(8'h21, 2, 0, 1'b0, w);
        if (w != 0) begin
            $display("FAIL wrap_first: got %0d want 0", w);
            n_bad++;
        end
        n_cmp++;
        run_txn(8'h20, 2, 0, 1'b0, w);
        req = 8'd0;
    endtask

    task automatic test_timeout;
        int w;
        run_txn(8'h80, 99, 0, 1'b0, w);
        run_txn(8'h80, TO, 0, 1'b0, w);
        req = 8'd0;
    endtask

    task automatic test_reset_mid_busy;
        int w;
        run_txn(8'h10, 2, 0, 1'b0, w);
        req = 8'h08;
        tick;
        if (obs !== pk(3, 8'h08, 1'b1, 8'd0, 1'b0, 1'b1)) begin
            $display("FAIL pre_rst_grant: got %h want %h", obs, pk(3, 8'h08, 1'b1, 8'd0, 1'b0, 1'b1));
            n_bad++;
        end
        n_cmp++;
        tick;
        rst = 1'b1;
        tick;
        if (obs !== 22'd0) begin
            $display("FAIL mid_busy_rst: got %h want %h", obs, 22'd0);
            n_bad++;
        end
        n_cmp++;
        rst = 1'b0;
        ptr_m = 0;
        last_sel = 0;
        req = 8'd0;
        tick;
        if (obs !== 22'd0) begin
            $display("FAIL post_rst_no_ack: got %h want %h", obs, 22'd0);
            n_bad++;
        end
        n_cmp++;
        run_txn(8'h88, 2, 0, 1'b0, w);
        if (w != 3) begin
            $display("FAIL post_rst_ptr: got %0d want 3", w);
            n_bad++;
        end
        n_cmp++;
        req = 8'd0;
    endtask

    task automatic test_idle_done_and_drop;
        int w;
        req = 8'd0;
        for (int i = 0; i < 3; i++) begin
            alu_done = 1'b1;
            tick;
            alu_done = 1'b0;
            if (obs !== pk(last_sel, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0)) begin
                $display("FAIL idle_done: got %h want %h", obs, pk(last_sel, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0));
                n_bad++;
            end
            n_cmp++;
        end
        run_txn(8'h02, 3, 1, 1'b1, w);
        req = 8'd0;
    endtask

    task automatic test_random;
        int w;
        int idle_n;
        logic d;
        for (int t = 0; t < 24; t++) begin
            run_txn(8'($urandom_range(1, 255)), $urandom_range(1, TO + 2),
                    $urandom_range(0, TO), 1'($urandom_range(0, 1)), w);
            req = 8'd0;
            idle_n = $urandom_range(0, 2);
            for (int i = 0; i < idle_n; i++) begin
                d = 1'($urandom_range(0, 1));
                alu_done = d;
                tick;
                alu_done = 1'b0;
                if (obs !== pk(last_sel, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0)) begin
                    $display("FAIL rand_idle: got %h want %h", obs, pk(last_sel, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0));
                    n_bad++;
                end
                n_cmp++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'd0;
        alu_done = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_wrap;
        test_timeout;
        test_reset_mid_busy;
        test_idle_done_and_drop;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
